// File: rtl/quad_pkg.sv
// Shared encodings for the quadrature decoder: A/B phase states and decode results.
package quad_pkg;

  // Phase states as {a, b}; forward rotation visits them in the order listed.
  localparam logic [1:0] QS_00 = 2'b00;
  localparam logic [1:0] QS_10 = 2'b10;
  localparam logic [1:0] QS_11 = 2'b11;
  localparam logic [1:0] QS_01 = 2'b01;

  // Outcome of comparing the previous and current A/B state.
  typedef enum logic [1:0] {
    STEP_NONE = 2'd0,
    STEP_UP   = 2'd1,
    STEP_DN   = 2'd2,
    STEP_ERR  = 2'd3
  } step_e;

endpackage

// File: rtl/sync_ff.sv
// Single-bit multi-flop synchroniser with asynchronous active-low reset.
module sync_ff #(
  parameter int unsigned STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  // Shift the asynchronous input through the flop chain.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/quad_decoder.sv
// x4 quadrature decoder with built-in up/down position counter and illegal-edge flag.
module quad_decoder
  import quad_pkg::*;
#(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             quad_a,
  input  logic             quad_b,
  input  logic             enable,
  input  logic             clear,
  output logic [WIDTH-1:0] count,
  output logic             dir,
  output logic             step,
  output logic             err,
  output logic             err_sticky
);

  localparam int unsigned CW = $clog2(SYNC_STAGES + 1);

  logic             w_a;
  logic             w_b;
  logic [1:0]       w_ab;
  step_e            w_dec;

  logic [1:0]       r_prev_ab;
  logic             r_init;
  logic [CW-1:0]    r_init_cnt;
  logic [WIDTH-1:0] r_count;
  logic             r_dir;
  logic             r_step;
  logic             r_err;
  logic             r_err_sticky;

  sync_ff #(
    .STAGES (SYNC_STAGES)
  ) u_sync_a (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_d     (quad_a),
    .o_q     (w_a)
  );

  sync_ff #(
    .STAGES (SYNC_STAGES)
  ) u_sync_b (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_d     (quad_b),
    .o_q     (w_b)
  );

  assign w_ab = {w_a, w_b};

  // Classify the transition from the previous to the current synchronised state.
  always_comb begin
    w_dec = STEP_NONE;
    unique case ({r_prev_ab, w_ab})
      {QS_00, QS_10}, {QS_10, QS_11}, {QS_11, QS_01}, {QS_01, QS_00}: w_dec = STEP_UP;
      {QS_00, QS_01}, {QS_01, QS_11}, {QS_11, QS_10}, {QS_10, QS_00}: w_dec = STEP_DN;
      {QS_00, QS_11}, {QS_11, QS_00}, {QS_01, QS_10}, {QS_10, QS_01}: w_dec = STEP_ERR;
      default:                                                        w_dec = STEP_NONE;
    endcase
  end

  // Track previous state, register step/err/dir pulses and update the position count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_prev_ab    <= QS_00;
      r_init       <= 1'b0;
      r_init_cnt   <= '0;
      r_count      <= '0;
      r_dir        <= 1'b0;
      r_step       <= 1'b0;
      r_err        <= 1'b0;
      r_err_sticky <= 1'b0;
    end else begin
      r_prev_ab <= w_ab;
      r_step    <= 1'b0;
      r_err     <= 1'b0;
      if (!r_init) begin
        // Synchroniser flops come out of reset at 0; wait until they hold the real pin
        // levels before taking the reference state, so a non-zero power-up position
        // never looks like an edge.
        r_init_cnt <= r_init_cnt + CW'(1);
        if (r_init_cnt == CW'(SYNC_STAGES)) begin
          r_init <= 1'b1;
        end
      end else begin
        unique case (w_dec)
          STEP_UP: begin
            r_step <= 1'b1;
            r_dir  <= 1'b1;
            if (enable) r_count <= r_count + WIDTH'(1);
          end
          STEP_DN: begin
            r_step <= 1'b1;
            r_dir  <= 1'b0;
            if (enable) r_count <= r_count - WIDTH'(1);
          end
          STEP_ERR: begin
            r_err        <= 1'b1;
            r_err_sticky <= 1'b1;
          end
          STEP_NONE: ;
        endcase
      end
      // Clear wins over any count or sticky update in the same cycle.
      if (clear) begin
        r_count      <= '0;
        r_err_sticky <= 1'b0;
      end
    end
  end

  assign count      = r_count;
  assign dir        = r_dir;
  assign step       = r_step;
  assign err        = r_err;
  assign err_sticky = r_err_sticky;

endmodule

// File: tb/tb_quad_decoder.sv
// Self-checking bench for quad_decoder against a phase-arithmetic position model.
module tb_quad_decoder;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned SYNC  = 2;
  localparam int unsigned LAT   = SYNC + 1;

  logic             clk;
  logic             reset;
  logic             quad_a;
  logic             quad_b;
  logic             enable;
  logic             clear;
  logic [WIDTH-1:0] count;
  logic             dir;
  logic             step;
  logic             err;
  logic             err_sticky;

  int n_cmp;
  int n_bad;

  // Reference model state
  logic [1:0]       m_ab;
  logic [WIDTH-1:0] m_count;
  logic             m_dir;
  logic             m_sticky;

  quad_decoder #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .quad_a     (quad_a),
    .quad_b     (quad_b),
    .enable     (enable),
    .clear      (clear),
    .count      (count),
    .dir        (dir),
    .step       (step),
    .err        (err),
    .err_sticky (err_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Position of an A/B state around the encoder cycle 00,10,11,01.
  function automatic int phase(input logic [1:0] ab);
    case (ab)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [1:0] state_at(input int ph);
    case (((ph % 4) + 4) % 4)
      0:       return 2'b00;
      1:       return 2'b10;
      2:       return 2'b11;
      default: return 2'b01;
    endcase
  endfunction

  task automatic do_reset(input logic [1:0] ab);
    reset  = 1'b0;
    quad_a = ab[1];
    quad_b = ab[0];
    m_ab     = ab;
    m_count  = '0;
    m_dir    = 1'b0;
    m_sticky = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    repeat (6) @(posedge clk);
    #1;
  endtask

  // Drive a new A/B state, hold it, and check the cycle-exact response.
  task automatic apply(input logic [1:0] ab, input int hold, input bit clr_at_lat);
    int               d;
    bit               exp_step;
    bit               exp_err;
    logic [WIDTH-1:0] old_count;
    d         = (phase(ab) - phase(m_ab) + 4) % 4;
    exp_step  = (d == 1) || (d == 3);
    exp_err   = (d == 2);
    old_count = m_count;
    if (d == 1) begin
      m_dir = 1'b1;
      if (enable) m_count = m_count + 1'b1;
    end else if (d == 3) begin
      m_dir = 1'b0;
      if (enable) m_count = m_count - 1'b1;
    end else if (d == 2) begin
      m_sticky = 1'b1;
    end
    if (clr_at_lat) begin
      m_count  = '0;
      m_sticky = 1'b0;
    end
    m_ab   = ab;
    quad_a = ab[1];
    quad_b = ab[0];
    for (int i = 1; i <= hold; i++) begin
      if (clr_at_lat && i == LAT) clear = 1'b1;
      @(posedge clk);
      #1;
      clear = 1'b0;
      n_cmp++;
      if (step !== (exp_step && i == LAT)) begin
        n_bad++;
        $display("FAIL step ab=%b cyc=%0d got=%b want=%b", ab, i, step, exp_step && i == LAT);
      end
      n_cmp++;
      if (err !== (exp_err && i == LAT)) begin
        n_bad++;
        $display("FAIL err ab=%b cyc=%0d got=%b want=%b", ab, i, err, exp_err && i == LAT);
      end
      n_cmp++;
      if (count !== ((i >= LAT) ? m_count : old_count)) begin
        n_bad++;
        $display("FAIL count ab=%b cyc=%0d got=%0d want=%0d", ab, i, count,
                 (i >= LAT) ? m_count : old_count);
      end
    end
    n_cmp++;
    if (dir !== m_dir) begin
      n_bad++;
      $display("FAIL dir ab=%b got=%b want=%b", ab, dir, m_dir);
    end
    n_cmp++;
    if (err_sticky !== m_sticky) begin
      n_bad++;
      $display("FAIL err_sticky ab=%b got=%b want=%b", ab, err_sticky, m_sticky);
    end
  endtask

  task automatic check_zero(input string tag);
    n_cmp++;
    if ({count, dir, step, err, err_sticky} !== '0) begin
      n_bad++;
      $display("FAIL %s count=%0d dir=%b step=%b err=%b sticky=%b want all 0",
               tag, count, dir, step, err, err_sticky);
    end
  endtask

  task automatic test_reset();
    reset  = 1'b0;
    quad_a = 1'b0;
    quad_b = 1'b0;
    enable = 1'b1;
    clear  = 1'b0;
    #2;
    check_zero("reset_async");
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset_held");
  endtask

  task automatic test_forward();
    do_reset(2'b00);
    enable = 1'b1;
    apply(2'b10, 4, 1'b0);
    apply(2'b11, 4, 1'b0);
    apply(2'b01, 4, 1'b0);
    apply(2'b00, 4, 1'b0);
  endtask

  task automatic test_reverse_wrap();
    do_reset(2'b00);
    apply(2'b01, 4, 1'b0);
    apply(2'b11, 4, 1'b0);
    apply(2'b10, 4, 1'b0);
    for (int k = 0; k < 12; k++) apply(state_at(phase(m_ab) + 1), 4, 1'b0);
  endtask

  task automatic test_illegal();
    do_reset(2'b00);
    apply(2'b11, 4, 1'b0);
    apply(2'b01, 4, 1'b0);
  endtask

  task automatic test_powerup_nonzero();
    do_reset(2'b11);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if (step !== 1'b0 || err !== 1'b0 || count !== '0) begin
        n_bad++;
        $display("FAIL powerup_quiet step=%b err=%b count=%0d want 0/0/0", step, err, count);
      end
    end
    apply(2'b01, 4, 1'b0);
  endtask

  task automatic test_enable_clear();
    do_reset(2'b00);
    enable = 1'b0;
    apply(2'b11, 4, 1'b0);
    apply(2'b01, 4, 1'b0);
    apply(2'b00, 4, 1'b0);
    apply(2'b10, 4, 1'b0);
    enable = 1'b1;
    apply(2'b11, 4, 1'b1);
    apply(2'b01, 4, 1'b0);
  endtask

  task automatic test_reset_mid_motion();
    do_reset(2'b00);
    for (int k = 0; k < 7; k++) apply(state_at(phase(m_ab) + 1), 4, 1'b0);
    #2 reset = 1'b0;
    #1 reset = 1'b1;
    #1;
    check_zero("reset_mid");
    m_count  = '0;
    m_dir    = 1'b0;
    m_sticky = 1'b0;
    @(posedge clk);
    #1;
    check_zero("reset_first_clk");
    repeat (6) @(posedge clk);
    #1;
    apply(state_at(phase(m_ab) - 1), 4, 1'b0);
  endtask

  task automatic test_random();
    int r;
    do_reset(2'b00);
    for (int k = 0; k < 60; k++) begin
      enable = ($urandom_range(0, 4) != 0);
      r = $urandom_range(0, 9);
      if (r == 0)      apply(state_at(phase(m_ab) + 2), $urandom_range(LAT, LAT + 3), 1'b0);
      else if (r < 6)  apply(state_at(phase(m_ab) + 1), $urandom_range(LAT, LAT + 3),
                             $urandom_range(0, 9) == 0);
      else             apply(state_at(phase(m_ab) - 1), $urandom_range(LAT, LAT + 3),
                             $urandom_range(0, 9) == 0);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_forward();
    test_reverse_wrap();
    test_illegal();
    test_powerup_nonzero();
    test_enable_clear();
    test_reset_mid_motion();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
